// File: rtl/adder_op_issue.sv
// adder_op_issue
//   Operand issue-and-capture stage around an external 32-bit carry-lookahead adder.
//   Requests {a, b, sub, tag} are buffered in a DEPTH-entry FIFO. The FIFO head
//   drives the adder combinationally. For subtraction, B is inverted and carry-in
//   is forced high. The adder result is registered into a single-entry output stage
//   with a valid/ready handshake. Saturating counters track delivered results and
//   delivered overflows.
//
// Ports
//   clk, rst               : clock and synchronous active-high reset
//   in_valid/in_ready      : request handshake
//   in_a, in_b             : operands
//   in_sub                 : request type (1 = A-B, 0 = A+B)
//   in_tag                 : request ID
//   add_a/add_b/add_cin    : operands to the external adder
//   add_s/add_cout/add_ovf : combinational result from the adder
//   out_valid/out_ready    : result handshake
//   out_sum, out_cout, out_ovf, out_zero, out_neg, out_tag : registered result
//   ops_count, ovf_count   : saturating statistics
module adder_op_issue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  input  logic [3:0]       in_tag,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_cin,
  input  logic [31:0]      add_s,
  input  logic             add_cout,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [3:0]       out_tag,
  output logic [CNT_W-1:0] ops_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state, state_next;

  logic [31:0]   fifo_a   [DEPTH];
  logic [31:0]   fifo_b   [DEPTH];
  logic          fifo_sub [DEPTH];
  logic [3:0]    fifo_tag [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic push;
  logic pop;
  logic nonempty;
  logic capture;
  logic deliver;

  // in_ready looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready = !rst && (count < DEPTH_CNT);
  assign push     = in_valid && in_ready;
  assign nonempty = (count != '0);
  assign capture  = nonempty && (!out_valid || out_ready);
  assign pop      = capture;
  assign deliver  = out_valid && out_ready;

  // FIFO storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr]   <= in_a;
      fifo_b[wr_ptr]   <= in_b;
      fifo_sub[wr_ptr] <= in_sub;
      fifo_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The adder sees only the FIFO head; in_* is never bypassed.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (nonempty) begin
      add_a   = fifo_a[rd_ptr];
      add_b   = fifo_sub[rd_ptr] ? ~fifo_b[rd_ptr] : fifo_b[rd_ptr];
      add_cin = fifo_sub[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (capture) state_next = S_FULL;
      S_FULL:  if (out_ready && !capture) state_next = S_EMPTY;
      default: state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == S_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b1;
      out_neg  <= 1'b0;
      out_tag  <= '0;
    end else if (capture) begin
      out_sum  <= add_s;
      out_cout <= add_cout;
      out_ovf  <= add_ovf;
      out_zero <= (add_s == '0);
      out_neg  <= add_s[31];
      out_tag  <= fifo_tag[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_count <= '0;
      ovf_count <= '0;
    end else if (deliver) begin
      if (ops_count != CNT_MAX)            ops_count <= ops_count + 1'b1;
      if (out_ovf && ovf_count != CNT_MAX) ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_op_issue.sv
// tb_adder_op_issue
//   Directed bench for adder_op_issue. The bench provides a behavioural 32-bit
//   adder model for the external adder path. A second instance with CNT_W=4
//   shares all inputs with the main instance and is used for counter saturation.
module tb_adder_op_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic [31:0] add_a, add_b, add_s;
  logic        add_cin, add_cout, add_ovf;
  logic        out_valid, out_cout, out_ovf, out_zero, out_neg;
  logic [31:0] out_sum;
  logic [3:0]  out_tag;
  logic [15:0] ops_count, ovf_count;

  logic [31:0] add2_a, add2_b, add2_s;
  logic        add2_cin, add2_cout, add2_ovf;
  logic        in_ready2, out_valid2, out_cout2, out_ovf2, out_zero2, out_neg2;
  logic [31:0] out_sum2;
  logic [3:0]  out_tag2;
  logic [3:0]  ops_count2, ovf_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s}   = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_ovf             = (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
  assign {add2_cout, add2_s} = {1'b0, add2_a} + {1'b0, add2_b} + {32'd0, add2_cin};
  assign add2_ovf            = (add2_a[31] == add2_b[31]) && (add2_s[31] != add2_a[31]);

  adder_op_issue #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_neg(out_neg), .out_tag(out_tag),
    .ops_count(ops_count), .ovf_count(ovf_count)
  );

  adder_op_issue #(.DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .add_a(add2_a), .add_b(add2_b), .add_cin(add2_cin),
    .add_s(add2_s), .add_cout(add2_cout), .add_ovf(add2_ovf),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_cout(out_cout2), .out_ovf(out_ovf2),
    .out_zero(out_zero2), .out_neg(out_neg2), .out_tag(out_tag2),
    .ops_count(ops_count2), .ovf_count(ovf_count2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = tag;
  endtask

  // One isolated request: push, capture, inspect, deliver.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [3:0] tag, input logic [31:0] e_sum, input logic e_cout,
                       input logic e_ovf, input logic e_zero, input logic e_neg);
    out_ready = 1'b0;
    drive(a, b, sub, tag);
    #1;
    check("no_bypass_a", {32'd0, add_a}, 64'd0);
    tick();
    in_valid = 1'b0;
    check("drive_a",   {32'd0, add_a}, {32'd0, a});
    check("drive_b",   {32'd0, add_b}, {32'd0, (sub ? ~b : b)});
    check("drive_cin", {63'd0, add_cin}, {63'd0, sub});
    check("lat_valid0", {63'd0, out_valid}, 64'd0);
    tick();
    check("op_valid", {63'd0, out_valid}, 64'd1);
    check("op_sum",   {32'd0, out_sum}, {32'd0, e_sum});
    check("op_cout",  {63'd0, out_cout}, {63'd0, e_cout});
    check("op_ovf",   {63'd0, out_ovf}, {63'd0, e_ovf});
    check("op_zero",  {63'd0, out_zero}, {63'd0, e_zero});
    check("op_neg",   {63'd0, out_neg}, {63'd0, e_neg});
    check("op_tag",   {60'd0, out_tag}, {60'd0, tag});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("op_done", {63'd0, out_valid}, 64'd0);
  endtask

  // Continuous add stream with out_ready held high. Result k carries
  // tag tag0+k and sum a0+astep*k+b.
  task automatic stream(input int n, input logic [31:0] a0, input logic [31:0] astep,
                        input logic [31:0] b, input logic [3:0] tag0,
                        output int rcv, output int gaps);
    int sent;
    logic started;
    logic [31:0] e_sum;
    logic [3:0] e_tag;
    sent    = 0;
    rcv     = 0;
    gaps    = 0;
    started = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4 * n + 10 && rcv < n; cyc++) begin
      if (sent < n) drive(a0 + astep * sent, b, 1'b0, tag0 + 4'(sent));
      else          in_valid = 1'b0;
      #1;
      if (out_valid) begin
        e_sum = a0 + astep * rcv + b;
        e_tag = tag0 + 4'(rcv);
        check("stream_tag", {60'd0, out_tag}, {60'd0, e_tag});
        check("stream_sum", {32'd0, out_sum}, {32'd0, e_sum});
        started = 1'b1;
        rcv++;
      end else if (started) begin
        gaps++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rcv, gaps;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_valid",    {63'd0, out_valid}, 64'd0);
    check("rst_zero",     {63'd0, out_zero}, 64'd1);
    check("rst_sum",      {32'd0, out_sum}, 64'd0);
    check("rst_ops",      {48'd0, ops_count}, 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);
    check("idle_add_cin",  {63'd0, add_cin}, 64'd0);

    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 4'd1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 4'd2, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0005, 1'b1, 4'd3, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b1, 4'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure. Tag 1 occupies the result register and tags 2..5 fill the FIFO.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(32'(16 * k), 32'(k), 1'b0, 4'(k));
      tick();
    end
    in_valid = 1'b0;
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    check("hold_valid", {63'd0, out_valid}, 64'd1);
    check("hold_tag",   {60'd0, out_tag}, 64'd1);
    check("hold_sum",   {32'd0, out_sum}, 64'd17);
    check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    // A request offered while full must be refused even though a pop happens.
    out_ready = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 4'd9);
    for (int k = 1; k <= 5; k++) begin
      check("drain_valid", {63'd0, out_valid}, 64'd1);
      check("drain_tag",   {60'd0, out_tag}, 64'(k));
      check("drain_sum",   {32'd0, out_sum}, 64'(17 * k));
      tick();
      in_valid = 1'b0;
    end
    check("drain_empty", {63'd0, out_valid}, 64'd0);
    check("ops_after_bp", {48'd0, ops_count}, 64'd9);
    check("ovf_after_bp", {48'd0, ovf_count}, 64'd1);

    // Reset with three entries buffered and a result pending.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(32'(k), 32'd0, 1'b0, 4'(k));
      tick();
    end
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    drive(32'd7, 32'd7, 1'b0, 4'd7);
    #1;
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_ops",   {48'd0, ops_count}, 64'd0);
    check("rst_mid_ovf",   {48'd0, ovf_count}, 64'd0);
    check("rst_mid_tag",   {60'd0, out_tag}, 64'd0);
    rst = 1'b0;
    drive(32'd1, 32'd2, 1'b0, 4'hA);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst_tag",   {60'd0, out_tag}, 64'hA);
    check("post_rst_sum",   {32'd0, out_sum}, 64'd3);
    tick();
    check("post_rst_empty", {63'd0, out_valid}, 64'd0);
    check("post_rst_ops",   {48'd0, ops_count}, 64'd1);

    // Streaming throughput.
    stream(20, 32'd0, 32'd1, 32'd100, 4'd0, rcv, gaps);
    check("stream_count", 64'(rcv), 64'd20);
    check("stream_gaps",  64'(gaps), 64'd0);
    check("stream_ops",   {48'd0, ops_count}, 64'd21);
    check("stream_empty", {63'd0, out_valid}, 64'd0);

    // Saturation. Every result overflows; the 4-bit counters stop at 15.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_rst_ops", {60'd0, ops_count2}, 64'd0);
    stream(20, 32'h7FFF_FFFF, 32'd0, 32'd1, 4'd3, rcv, gaps);
    check("sat_count", 64'(rcv), 64'd20);
    check("sat_ops",   {60'd0, ops_count2}, 64'd15);
    check("sat_ovf",   {60'd0, ovf_count2}, 64'd15);
    check("wide_ops",  {48'd0, ops_count}, 64'd20);
    check("wide_ovf",  {48'd0, ovf_count}, 64'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
